hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It drives the PC write-enable, the IF/ID register write-enable and flush, and the ID/EX bubble insert. It detects load-use hazards, holds the front end for multi-cycle multiply/divide operations, and squashes wrong-path fetches on taken branches. Saturating performance counters for stall and flush cycles are exported for debug.

## Interface
Parameters:
- MDU_LATENCY, 4, number of stall cycles a multiply/divide holds in ID; legal range 1..15
- REG_W, 5, register index width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rs  in  REG_W  source register A of the instruction in ID
- id_rt  in  REG_W  source register B of the instruction in ID
- id_rs_used  in  1  instruction in ID reads id_rs
- id_rt_used  in  1  instruction in ID reads id_rt
- id_mdu_op  in  1  instruction in ID is a multi-cycle multiply/divide
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination register of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken; PC mux selects target this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID register loads zero (NOP) this edge
- id_ex_bubble  out  1  ID/EX register loads NOP this edge
- ctrl_state  out  1  0 = RUN, 1 = MDU_BUSY (debug)
- stall_count  out  32  cycles with pc_write = 0, saturating
- flush_count  out  16  cycles with if_id_flush = 1 from a branch, saturating

## Operation
- States: RUN, MDU_BUSY. A 4-bit down-counter (mdu_cnt) is active only in MDU_BUSY.
- load_use = ex_mem_read && ex_rd != 0 && ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd)).
- Priority per cycle: reset > branch > load_use > MDU.
- Branch (either state): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
  - Next state is RUN and mdu_cnt is cleared. A pending MDU op is on the wrong path and is cancelled.
  - flush_count increments.
- RUN with load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0. State stays RUN.
- RUN with id_mdu_op and no load_use: outputs as the load_use stall. Next state is MDU_BUSY and mdu_cnt is loaded with MDU_LATENCY-1.
- RUN otherwise: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- MDU_BUSY with mdu_cnt != 0: stall outputs and mdu_cnt decrements. load_use is ignored, because EX holds bubbles.
- MDU_BUSY with mdu_cnt == 0: release cycle. Outputs as normal RUN, so the MDU op advances to EX. Next state is RUN, so the op cannot retrigger.
- Total front-end stall for an MDU op is exactly MDU_LATENCY cycles. MDU_LATENCY=1 gives one stall cycle, then release.
- stall_count increments on every cycle with pc_write=0 and holds at 0xFFFF_FFFF. flush_count holds at 0xFFFF.

## Timing
- All outputs except the counters and ctrl_state are combinational from state, mdu_cnt and the current inputs. They are consumed at the same rising edge.
- Counters and ctrl_state are registered and reflect cycles up to the previous edge.
- While reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1.
- The first edge with reset=1 sets:
  - state to RUN
  - mdu_cnt to 0
  - stall_count to 0
  - flush_count to 0
- Reset during MDU_BUSY aborts the wait. The first cycle after reset is a RUN cycle.
- Reset cycles are counted in neither counter.
- Load-use costs exactly one bubble. The stalled instruction re-evaluates next cycle with the bubble in EX.

## Structure
- Package hazard_pkg:
  - state enum ctrl_state_t {RUN, MDU_BUSY}
  - REG_ZERO constant (index 0)
  - NOP encoding 32'h0000_0000, shared with the IF/ID and ID/EX registers
- One natural sub-module: load_use_detect. It is purely combinational, with register-compare logic only, and is reused by the forwarding unit.
- The FSM, mdu_cnt and counters live in hazard_ctrl.

## Test plan
- **Load-use:**
  - Stimulus: ex_mem_read=1, ex_rd=5, id_rs=5, id_rs_used=1.
  - Response: exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1.
  - stall_count goes 0→1.
- **Zero register:** same as load-use with ex_rd=0, id_rs=0. No stall; pc_write=1.
- **MDU latency:**
  - Stimulus: MDU_LATENCY=4, id_mdu_op=1 for one instruction.
  - Response: 4 stall cycles, then release with pc_write=1 and id_ex_bubble=0.
  - stall_count=4; back in RUN afterwards.
- **Branch mid-MDU:** ex_branch_taken=1 during the 2nd MDU_BUSY cycle. Same cycle: if_id_flush=1, id_ex_bubble=1, pc_write=1. Next state RUN; flush_count=1.
- **Branch plus load-use:** both conditions in the same cycle. Branch wins: pc_write=1, if_id_flush=1, no stall counted.
- **Reset and saturation:**
  - Reset asserted in MDU_BUSY: the first post-reset cycle is RUN with both counters 0.
  - A forced stall_count near 0xFFFF_FFFF holds at max under continued stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package hazard_pkg;

    localparam int unsigned MDU_CNT_W   = 4;
    localparam int unsigned STALL_CNT_W = 32;
    localparam int unsigned FLUSH_CNT_W = 16;
    localparam int unsigned REG_ZERO    = 0;

    // NOP word loaded by IF/ID flush and ID/EX bubble
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam pipe_ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1};
    localparam pipe_ctrl_t CTRL_RESET = '{1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX observation inputs and pipeline control outputs.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_mdu_op;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ctrl_state;
    logic [31:0]      stall_count;
    logic [15:0]      flush_count;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_mdu_op,
               ex_mem_read, ex_rd, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               ctrl_state, stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_mdu_op,
               ex_mem_read, ex_rd, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               ctrl_state, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between a load in EX and the sources read in ID.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use
);
    // Writes to the zero register never create a dependency
    assign load_use = ex_mem_read && (ex_rd != REG_W'(REG_ZERO))
                   && ((id_rs_used && (id_rs == ex_rd))
                    || (id_rt_used && (id_rt == ex_rd)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, MDU front-end hold,
// branch squash, and saturating stall/flush debug counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned REG_W       = 5
) (
    input logic        clk,
    input logic        reset,
    hazard_ctrl_if.slave hz
);
    ctrl_state_t            state_q, state_d;
    logic [MDU_CNT_W-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q;
    pipe_ctrl_t             ctrl;
    logic                   load_use;
    logic                   flush_evt;

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .id_rs       (hz.id_rs),
        .id_rt       (hz.id_rt),
        .id_rs_used  (hz.id_rs_used),
        .id_rt_used  (hz.id_rt_used),
        .ex_mem_read (hz.ex_mem_read),
        .ex_rd       (hz.ex_rd),
        .load_use    (load_use)
    );

    // Next state and same-cycle pipeline controls; branch overrides any stall
    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        ctrl      = CTRL_RUN;
        flush_evt = 1'b0;
        if (reset) begin
            ctrl      = CTRL_RESET;
            state_d   = RUN;
            mdu_cnt_d = '0;
        end else if (hz.ex_branch_taken) begin
            ctrl      = CTRL_FLUSH;
            state_d   = RUN;
            mdu_cnt_d = '0;
            flush_evt = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load_use) begin
                        ctrl = CTRL_STALL;
                    end else if (hz.id_mdu_op) begin
                        ctrl      = CTRL_STALL;
                        state_d   = MDU_BUSY;
                        mdu_cnt_d = MDU_CNT_W'(MDU_LATENCY - 1);
                    end
                end
                MDU_BUSY: begin
                    // EX only holds bubbles here, so load_use cannot apply
                    if (mdu_cnt_q != '0) begin
                        ctrl      = CTRL_STALL;
                        mdu_cnt_d = mdu_cnt_q - MDU_CNT_W'(1);
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
            if (!ctrl.pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
            if (flush_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + FLUSH_CNT_W'(1);
            end
        end
    end

    assign hz.pc_write     = ctrl.pc_write;
    assign hz.if_id_write  = ctrl.if_id_write;
    assign hz.if_id_flush  = ctrl.if_id_flush;
    assign hz.id_ex_bubble = ctrl.id_ex_bubble;
    assign hz.ctrl_state   = state_q;
    assign hz.stall_count  = stall_cnt_q;
    assign hz.flush_count  = flush_cnt_q;

endmodule
